draw_text_box: RTL and testbench
================================

Name: draw_text_box

Overview:
- Parametrised text-overlay stage in the VGA timing chain; successor to the fixed-geometry char drawer.
- Draws a COLS x ROWS grid of 8x16 glyphs at a runtime-movable position.
- Drives the font/char-ROM address and absorbs a configurable ROM read latency by delaying all timing signals.
- Adds opaque-background mode, foreground blink, and tear-free position update latched at frame start.

Parameters:
- COLS, 21: character columns in the box.
- ROWS, 16: character rows in the box.
- COL_BITS, 5: width of the column field in char_xy; 2^COL_BITS >= COLS.
- ROW_BITS, 4: width of the row field in char_xy; 2^ROW_BITS >= ROWS.
- ROM_LAT, 1: char-ROM read latency in clk cycles, >= 1.
- BLINK_FRAMES, 30: frames per blink half-period, >= 1.
- XPOS_INIT, 427: box left edge after reset.
- YPOS_INIT, 100: box top edge after reset.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; asynchronous, active-high.
- hcount_in, vcount_in  in  11 each  pixel counters.
- hsync_in, hblnk_in, vsync_in, vblnk_in  in  1 each  timing signals.
- rgb_in  in  12  upstream pixel.
- char_pixels  in  8  glyph row from ROM; MSB is the leftmost pixel.
- xpos, ypos  in  11 each  requested box origin.
- fg_color, bg_color  in  12 each  glyph and background colours.
- bg_en  in  1  1 = fill non-glyph box pixels with bg_color.
- blink_en  in  1  1 = enable foreground blink.
- hcount_out, vcount_out  out  11 each  delayed counters.
- hsync_out, hblnk_out, vsync_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited pixel.
- char_xy  out  ROW_BITS+COL_BITS  ROM address {row, col}, registered.
- char_line  out  4  glyph line 0..15, registered.

Behaviour:
- Reset (async, rst=1): all outputs 0; x_org=XPOS_INIT, y_org=YPOS_INIT; frame counter 0; blink_phase 0; all pipeline stages 0.
- Frame latch: vsync rising edge detected via a registered copy of vsync_in. On that clk edge, x_org<=xpos and y_org<=ypos. xpos/ypos changes mid-frame have no visible effect until the next vsync rise.
- Stage A (cycle 1):
  - dx = hcount_in - x_org, dy = vcount_in - y_org, 11-bit wrap.
  - in_box = (hcount_in >= x_org) && (hcount_in < x_org + COLS*8) && (vcount_in >= y_org) && (vcount_in < y_org + ROWS*16).
  - Bounds are computed in 12 bits so a box near 2047 does not wrap.
  - char_xy <= {dy[ROW_BITS+3:4], dx[COL_BITS+2:3]}; char_line <= dy[3:0]. Both update every cycle, in or out of the box.
  - Register in_box, bit index = 7 - dx[2:0], timing, counters, and rgb_in.
- Delay: stage-A signals pass through ROM_LAT further register stages so they align with char_pixels.
- Output stage (1 cycle):
  - Delayed hblnk or vblnk = 1 -> rgb_out = 0.
  - Else if in_box and char_pixels[bit] = 1 and !(blink_en && blink_phase) -> fg_color.
  - Else if in_box and bg_en -> bg_color.
  - Else -> delayed rgb_in.
- Latency: every *_out lags its *_in by ROM_LAT+2 cycles (3 at default). char_xy/char_line lag the inputs by 1 cycle.
- Blink: the frame counter increments on each vsync rise. At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase. The counter runs even when blink_en=0.
- Edge pixels: the first box pixel is hcount == x_org (glyph bit 7); the last is x_org + COLS*8 - 1.
- Reset mid-frame clears the pipeline immediately; the output is black/zero until fresh inputs propagate through.

Decomposition:
- Shared package: CHAR_W=8, CHAR_H=16, RGB_W=12, CNT_W=11, plus colour constants for black and white.
- One sub-module, sig_delay: parametrised WIDTH x DEPTH shift register with async active-high reset. Used for the timing/rgb bus and for the in_box/bit-index bus.

Test Plan:
- Latency check: ROM_LAT=1; pulse hsync_in for 1 cycle -> hsync_out pulses exactly 3 cycles later. With ROM_LAT=3 -> 5 cycles later.
- Addressing: x_org=427, y_org=100; drive h=443, v=133 -> one cycle later char_xy={row 2, col 2}=9'h042, char_line=1.
- Glyph pixel: h=427 with char_pixels=8'h80 -> rgb_out=fg_color. h=426 -> rgb_in. h=427+168=595 -> rgb_in even if char_pixels=FF.
- Background: bg_en=1, char_pixels=0 inside box -> bg_color. bg_en=0 -> rgb_in. Any blank cycle -> rgb_out=0.
- Position latch: change xpos to 100 mid-frame -> no change until after the next vsync rise; the following frame's box starts at h=100.
- Blink and reset: BLINK_FRAMES=2, blink_en=1 -> glyph absent on frames 2-3, present on 4-5. Assert rst mid-line -> all outputs 0 asynchronously, then x_org returns to 427.

Source files
------------

// File: rtl/draw_text_box_pkg.sv
// Shared constants and the timing bundle that travels alongside each pixel through the
// text-box pipeline.
package draw_text_box_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned CHAR_H = 16;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned CNT_W  = 11;

  localparam logic [RGB_W-1:0] RGB_BLACK = 12'h000;
  localparam logic [RGB_W-1:0] RGB_WHITE = 12'hfff;

  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             hblnk;
    logic             vsync;
    logic             vblnk;
    logic [RGB_W-1:0] rgb;
  } timing_t;

endpackage

// File: rtl/draw_text_box_sig_delay.sv
// WIDTH x DEPTH register chain with asynchronous active-high reset; DEPTH must be >= 1.
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/draw_text_box.sv
// Text-overlay stage: addresses the char ROM from the pixel counters and composites glyph,
// background or upstream pixel once the ROM data has arrived.
module draw_text_box
  import draw_text_box_pkg::*;
#(
  parameter int unsigned COLS         = 21,
  parameter int unsigned ROWS         = 16,
  parameter int unsigned COL_BITS     = 5,
  parameter int unsigned ROW_BITS     = 4,
  parameter int unsigned ROM_LAT      = 1,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned XPOS_INIT    = 427,
  parameter int unsigned YPOS_INIT    = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CNT_W-1:0]             hcount_in,
  input  logic [CNT_W-1:0]             vcount_in,
  input  logic                         hsync_in,
  input  logic                         hblnk_in,
  input  logic                         vsync_in,
  input  logic                         vblnk_in,
  input  logic [RGB_W-1:0]             rgb_in,
  input  logic [7:0]                   char_pixels,
  input  logic [CNT_W-1:0]             xpos,
  input  logic [CNT_W-1:0]             ypos,
  input  logic [RGB_W-1:0]             fg_color,
  input  logic [RGB_W-1:0]             bg_color,
  input  logic                         bg_en,
  input  logic                         blink_en,
  output logic [CNT_W-1:0]             hcount_out,
  output logic [CNT_W-1:0]             vcount_out,
  output logic                         hsync_out,
  output logic                         hblnk_out,
  output logic                         vsync_out,
  output logic                         vblnk_out,
  output logic [RGB_W-1:0]             rgb_out,
  output logic [ROW_BITS+COL_BITS-1:0] char_xy,
  output logic [3:0]                   char_line
);

  localparam int unsigned FCNT_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W:0] BOX_W = (CNT_W + 1)'(COLS * CHAR_W);
  localparam logic [CNT_W:0] BOX_H = (CNT_W + 1)'(ROWS * CHAR_H);

  logic              vsync_q;
  logic [CNT_W-1:0]  x_org_q, y_org_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              blink_phase_q;
  logic              vsync_rise;

  assign vsync_rise = vsync_in & ~vsync_q;

  // Origin only moves at frame start so a box never tears mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q       <= 1'b0;
      x_org_q       <= CNT_W'(XPOS_INIT);
      y_org_q       <= CNT_W'(YPOS_INIT);
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_rise) begin
        x_org_q <= xpos;
        y_org_q <= ypos;
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
      end
    end
  end

  logic [CNT_W-1:0] dx, dy;
  logic [CNT_W:0]   h_ext, v_ext, x_lo, y_lo;
  logic             in_box;

  // Bounds use one extra bit so a box near the counter limit does not wrap.
  always_comb begin
    dx     = hcount_in - x_org_q;
    dy     = vcount_in - y_org_q;
    h_ext  = {1'b0, hcount_in};
    v_ext  = {1'b0, vcount_in};
    x_lo   = {1'b0, x_org_q};
    y_lo   = {1'b0, y_org_q};
    in_box = (h_ext >= x_lo) && (h_ext < x_lo + BOX_W) &&
             (v_ext >= y_lo) && (v_ext < y_lo + BOX_H);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_xy   <= '0;
      char_line <= '0;
    end else begin
      char_xy   <= {dy[ROW_BITS+3:4], dx[COL_BITS+2:3]};
      char_line <= dy[3:0];
    end
  end

  timing_t    tim_a, tim_d;
  logic [3:0] box_a, box_d;

  always_comb begin
    tim_a.hcount = hcount_in;
    tim_a.vcount = vcount_in;
    tim_a.hsync  = hsync_in;
    tim_a.hblnk  = hblnk_in;
    tim_a.vsync  = vsync_in;
    tim_a.vblnk  = vblnk_in;
    tim_a.rgb    = rgb_in;
    box_a        = {in_box, 3'd7 - dx[2:0]};
  end

  // Stage A plus ROM_LAT stages lines the pixel context up with char_pixels.
  sig_delay #(
    .WIDTH ($bits(timing_t)),
    .DEPTH (ROM_LAT + 1)
  ) u_timing_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (tim_a),
    .q_o   (tim_d)
  );

  sig_delay #(
    .WIDTH (4),
    .DEPTH (ROM_LAT + 1)
  ) u_box_delay (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (box_a),
    .q_o   (box_d)
  );

  logic [RGB_W-1:0] rgb_d;
  logic             glyph_on;

  always_comb begin
    glyph_on = box_d[3] && char_pixels[box_d[2:0]] && !(blink_en && blink_phase_q);
    if (tim_d.hblnk || tim_d.vblnk) begin
      rgb_d = RGB_BLACK;
    end else if (glyph_on) begin
      rgb_d = fg_color;
    end else if (box_d[3] && bg_en) begin
      rgb_d = bg_color;
    end else begin
      rgb_d = tim_d.rgb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= tim_d.hcount;
      vcount_out <= tim_d.vcount;
      hsync_out  <= tim_d.hsync;
      hblnk_out  <= tim_d.hblnk;
      vsync_out  <= tim_d.vsync;
      vblnk_out  <= tim_d.vblnk;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_text_box.sv
// Scoreboard bench for draw_text_box: a behavioural model predicts every output frame of
// the main instance; a second instance with a longer ROM latency checks the delay depth.
module tb_draw_text_box;

  localparam int COLS = 21;
  localparam int ROWS = 16;
  localparam int LAT  = 3;
  localparam int BF   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in, xpos, ypos;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in, fg_color, bg_color;
  logic [7:0]  char_pixels;
  logic        bg_en, blink_en;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [8:0]  char_xy;
  logic [3:0]  char_line;

  logic [10:0] x3_hcount, x3_vcount;
  logic        x3_hsync, x3_hblnk, x3_vsync, x3_vblnk;
  logic [11:0] x3_rgb;
  logic [8:0]  x3_char_xy;
  logic [3:0]  x3_char_line;
  logic [7:0]  x3_pixels = 8'h00;

  always #5 clk = ~clk;

  draw_text_box #(.ROM_LAT(1), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(char_pixels), .xpos(xpos), .ypos(ypos),
    .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .blink_en(blink_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out),
    .hblnk_out(hblnk_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .char_xy(char_xy), .char_line(char_line)
  );

  draw_text_box #(.ROM_LAT(3), .BLINK_FRAMES(BF)) dut3 (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(x3_pixels), .xpos(xpos), .ypos(ypos),
    .fg_color(fg_color), .bg_color(bg_color), .bg_en(bg_en), .blink_en(blink_en),
    .hcount_out(x3_hcount), .vcount_out(x3_vcount), .hsync_out(x3_hsync),
    .hblnk_out(x3_hblnk), .vsync_out(x3_vsync), .vblnk_out(x3_vblnk),
    .rgb_out(x3_rgb), .char_xy(x3_char_xy), .char_line(x3_char_line)
  );

  // One-cycle char ROM; key/mode travel with the address so they stay aligned.
  logic [7:0] rom_key, key_q;
  logic       rom_mode, mode_q;

  function automatic logic [7:0] rom_fn(input logic [8:0] xy, input logic [3:0] ln,
                                        input logic [7:0] key, input logic mode);
    return mode ? (xy[7:0] ^ {ln, ln} ^ key) : key;
  endfunction

  always @(posedge clk) begin
    key_q       <= rom_key;
    mode_q      <= rom_mode;
    char_pixels <= rom_fn(char_xy, char_line, key_q, mode_q);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [37:0] exp_q[$];
  logic [12:0] addr_q[$];
  int  m_xo = 427, m_yo = 100, m_cnt = 0;
  bit  m_phase = 1'b0, m_vs_prev = 1'b0;
  logic hs_smp, hs3_smp;

  function automatic logic [37:0] out_vec();
    return {hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out};
  endfunction

  task automatic step(input int h, input int v, input logic hs, input logic hb,
                      input logic vs, input logic vb, input logic [11:0] rgb);
    int dx, dy, b;
    bit inb;
    logic [8:0] a;
    logic [3:0] ln;
    logic [7:0] pix;
    logic [11:0] er;
    @(negedge clk);
    hs_smp  = hsync_out;
    hs3_smp = x3_hsync;
    if (exp_q.size() >= LAT) check_eq("pipe", out_vec(), exp_q.pop_front());
    if (addr_q.size() >= 1) check_eq("addr", {char_line, char_xy}, addr_q.pop_front());
    hcount_in = 11'(h); vcount_in = 11'(v);
    hsync_in = hs; hblnk_in = hb; vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
    dx  = (h - m_xo) & 2047;
    dy  = (v - m_yo) & 2047;
    inb = (h >= m_xo) && (h < m_xo + COLS * 8) && (v >= m_yo) && (v < m_yo + ROWS * 16);
    a   = 9'(((dy >> 4) & 15) * 32 + ((dx >> 3) & 31));
    ln  = 4'(dy & 15);
    pix = rom_fn(a, ln, rom_key, rom_mode);
    b   = 7 - (dx & 7);
    if (hb || vb) er = 12'h000;
    else if (inb && pix[b] && !(blink_en && m_phase)) er = fg_color;
    else if (inb && bg_en) er = bg_color;
    else er = rgb;
    exp_q.push_back({11'(h), 11'(v), hs, hb, vs, vb, er});
    addr_q.push_back({ln, a});
    if (vs && !m_vs_prev) begin
      m_xo = int'(xpos);
      m_yo = int'(ypos);
      if (m_cnt == BF - 1) begin
        m_cnt = 0;
        m_phase = !m_phase;
      end else begin
        m_cnt++;
      end
    end
    m_vs_prev = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
  endtask

  task automatic frame_start();
    idle(3);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    idle(3);
  endtask

  task automatic set_cfg(input logic [7:0] key, input logic mode, input logic bge,
                         input logic blk);
    idle(3);
    rom_key = key; rom_mode = mode; bg_en = bge; blink_en = blk;
  endtask

  initial begin
    int lat1, lat3;
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 0; vsync_in = 0; vblnk_in = 0;
    rgb_in = '0; xpos = 11'd427; ypos = 11'd100;
    fg_color = 12'hf00; bg_color = 12'h00f; bg_en = 0; blink_en = 0;
    rom_key = 8'h80; rom_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", out_vec(), 38'h0);
    check_eq("reset_addr", {char_line, char_xy}, 13'h0);
    @(negedge clk);
    rst = 1'b0;

    // Delay depth of both instances.
    idle(4);
    step(0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h000);
    lat1 = -1; lat3 = -1;
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000);
      if (hs_smp && lat1 < 0) lat1 = k;
      if (hs3_smp && lat3 < 0) lat3 = k;
    end
    check_eq("latency_lat1", lat1, 3);
    check_eq("latency_lat3", lat3, 5);

    step(443, 133, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
    @(posedge clk);
    #1;
    check_eq("char_xy", char_xy, 9'h042);
    check_eq("char_line", char_line, 4'd1);

    // Glyph edges and bounds.
    step(427, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111);
    step(426, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h222);
    set_cfg(8'hff, 1'b0, 1'b0, 1'b0);
    step(595, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h333);
    step(594, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h444);
    step(500, 99, 1'b0, 1'b0, 1'b0, 1'b0, 12'h555);
    step(500, 355, 1'b0, 1'b0, 1'b0, 1'b0, 12'h666);
    step(500, 354, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777);

    // Background fill on and off, plus blanking.
    set_cfg(8'h00, 1'b0, 1'b1, 1'b0);
    step(430, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h888);
    step(430, 110, 1'b0, 1'b1, 1'b0, 1'b0, 12'h999);
    step(430, 110, 1'b0, 1'b0, 1'b0, 1'b1, 12'h999);
    set_cfg(8'h00, 1'b0, 1'b0, 1'b0);
    step(430, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'haaa);

    // Address-dependent glyphs across and around the box.
    set_cfg(8'h3c, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++)
      step(400 + $urandom_range(0, 220), 90 + $urandom_range(0, 280), 1'b0,
           1'($urandom_range(0, 7) == 0), 1'b0, 1'b0, 12'($urandom));

    // Origin change waits for the next frame.
    set_cfg(8'hff, 1'b0, 1'b0, 1'b0);
    xpos = 11'd100;
    step(427, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b1);
    step(150, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b2);
    frame_start();
    step(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b3);
    step(427, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b4);
    step(99, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b5);
    step(150, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0b6);

    // Asynchronous reset mid-line.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_out", out_vec(), 38'h0);
    check_eq("midrst_addr", {char_line, char_xy}, 13'h0);
    exp_q.delete();
    addr_q.delete();
    m_xo = 427; m_yo = 100; m_cnt = 0; m_phase = 1'b0; m_vs_prev = 1'b0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; hblnk_in = 1; vsync_in = 0; vblnk_in = 1;
    @(negedge clk);
    rst = 1'b0;
    step(427, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0c1);
    step(100, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0c2);

    // Blink: frames 2-3 hide the glyph, 4-5 show it.
    set_cfg(8'h80, 1'b0, 1'b0, 1'b1);
    for (int f = 1; f <= 5; f++) begin
      frame_start();
      step(427, 100, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0a0);
      idle(3);
    end

    idle(LAT + 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
